// File: rtl/ahb_sram_subordinate.sv
// AHB SRAM subordinate: wait states, strobed writes, write-to-read forwarding.
// Define AHB_SRAM_ERR_EN to enable size/alignment/range checking with two-cycle ERROR responses.
module ahb_sram_subordinate #(
   parameter int DataWidth  = 32,
   parameter int AddrWidth  = 32,
   parameter int Depth      = 256,
   parameter int WaitStates = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sel,
   input  logic [AddrWidth-1:0]     addr,
   input  logic                     write,
   input  logic [3:0]               size,
   input  logic [2:0]               burst,
   input  logic [2:0]               trans,
   input  logic [DataWidth-1:0]     wData,
   input  logic [DataWidth/8-1:0]   wStrb,
   input  logic                     ready,
   output logic                     readyOut,
   output logic [1:0]               resp,
   output logic [DataWidth-1:0]     rData
);
   localparam int Lanes = DataWidth / 8;
   localparam int Ofs   = $clog2(Lanes);
   localparam int IdxW  = $clog2(Depth);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t               state;
   state_t               nxt;
   logic [3:0]           cnt;
   logic [IdxW-1:0]      idx_q;
   logic                 wr_q;
   logic [DataWidth-1:0] mem [Depth];

   logic                 accept;
   logic                 err;
   logic                 we;
   logic                 fwd;
   logic [IdxW-1:0]      idx;
   logic [DataWidth-1:0] rd_next;
   logic                 unused_ok;

   assign idx    = addr[Ofs +: IdxW];
   assign accept = sel && ready && trans[1] &&
                   (state == S_IDLE || state == S_DATA || state == S_ERR2);
   assign we     = (state == S_DATA) && wr_q && ready && !reset;
   assign fwd    = we && (idx_q == idx);
   assign unused_ok = ^{burst, trans[0], size, addr};

`ifdef AHB_SRAM_ERR_EN
   logic [AddrWidth-1:0] full_idx;
   logic [Ofs-1:0]       align_mask;
   assign full_idx   = addr >> Ofs;
   assign align_mask = ~({Ofs{1'b1}} << size);
   assign err = (size > 4'(Ofs)) ||
                ((addr[Ofs-1:0] & align_mask) != '0) ||
                (full_idx >= AddrWidth'(Depth));
`else
   assign err = 1'b0;
`endif

   // Next-state decision; DATA and ERR2 hold while the bus stalls.
   always_comb begin
      nxt = state;
      case (state)
         S_WAIT:  nxt = (cnt == 4'd1) ? S_DATA : S_WAIT;
         S_ERR1:  nxt = S_ERR2;
         S_IDLE, S_DATA, S_ERR2: begin
            if (accept) begin
               if (err)                 nxt = S_ERR1;
               else if (WaitStates > 0) nxt = S_WAIT;
               else                     nxt = S_DATA;
            end else if (ready) begin
               nxt = S_IDLE;
            end else begin
               nxt = state;
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Read word merged with the write completing on the same edge.
   always_comb begin
      rd_next = '0;
      for (int b = 0; b < Lanes; b++) begin
         rd_next[b*8 +: 8] = (fwd && wStrb[b]) ? wData[b*8 +: 8] : mem[idx][b*8 +: 8];
      end
   end

   // Controller state, transfer attributes and registered bus outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         idx_q    <= '0;
         wr_q     <= 1'b0;
         readyOut <= 1'b1;
         resp     <= 2'd0;
         rData    <= '0;
      end else begin
         state    <= nxt;
         readyOut <= !(nxt == S_WAIT || nxt == S_ERR1);
         resp     <= (nxt == S_ERR1 || nxt == S_ERR2) ? 2'd1 : 2'd0;
         if (accept) begin
            idx_q <= idx;
            wr_q  <= write && !err;
            cnt   <= 4'(WaitStates);
            if (!write && !err) begin
               rData <= rd_next;
            end
         end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Byte-lane write at the edge that ends a write data phase; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < Lanes; b++) begin
            if (wStrb[b]) begin
               mem[idx_q][b*8 +: 8] <= wData[b*8 +: 8];
            end
         end
      end
   end
endmodule
